// File: rtl/wb_openram_arbiter.sv
// Round-robin arbiter sharing the RW port of one OpenRAM macro between two
// Wishbone slave ports; one access in flight, all macro and bus outputs registered.
module wb_openram_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_a_stb_i,
  input  logic                  wbs_a_cyc_i,
  input  logic                  wbs_a_we_i,
  input  logic [3:0]            wbs_a_sel_i,
  input  logic [31:0]           wbs_a_dat_i,
  input  logic [ADDR_WIDTH-1:0] wbs_a_adr_i,
  output logic                  wbs_a_ack_o,
  output logic [31:0]           wbs_a_dat_o,
  input  logic                  wbs_b_stb_i,
  input  logic                  wbs_b_cyc_i,
  input  logic                  wbs_b_we_i,
  input  logic [3:0]            wbs_b_sel_i,
  input  logic [31:0]           wbs_b_dat_i,
  input  logic [ADDR_WIDTH-1:0] wbs_b_adr_i,
  output logic                  wbs_b_ack_o,
  output logic [31:0]           wbs_b_dat_o,
  output logic                  ram_clk0,
  output logic                  ram_csb0,
  output logic                  ram_web0,
  output logic [3:0]            ram_wmask0,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [31:0]           ram_din0,
  input  logic [31:0]           ram_dout0,
  output logic                  grant_b_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic                    ptr_r, ptr_s;
  logic                    grant_b_r, grant_b_s;
  logic                    we_r, we_s;
  logic                    csb_r, csb_s;
  logic                    web_r, web_s;
  logic [3:0]              wmask_r, wmask_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [31:0]             din_r, din_s;
  logic                    ack_a_r, ack_a_s;
  logic                    ack_b_r, ack_b_s;
  logic [31:0]             dat_a_r, dat_a_s;
  logic [31:0]             dat_b_r, dat_b_s;
  logic                    busy_r, busy_s;
  logic                    req_a_s, req_b_s, win_b_s, owner_cyc_s;

  assign req_a_s     = wbs_a_cyc_i & wbs_a_stb_i;
  assign req_b_s     = wbs_b_cyc_i & wbs_b_stb_i;
  // Only the owner's cyc is watched after the grant, to detect an abort.
  assign owner_cyc_s = grant_b_r ? wbs_b_cyc_i : wbs_a_cyc_i;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    grant_b_s = grant_b_r;
    we_s      = we_r;
    csb_s     = csb_r;
    web_s     = web_r;
    wmask_s   = wmask_r;
    addr_s    = addr_r;
    din_s     = din_r;
    ack_a_s   = 1'b0;
    ack_b_s   = 1'b0;
    dat_a_s   = dat_a_r;
    dat_b_s   = dat_b_r;
    win_b_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_a_s & req_b_s) begin
          win_b_s = ptr_r;
        end else begin
          win_b_s = req_b_s;
        end
        if (req_a_s | req_b_s) begin
          grant_b_s = win_b_s;
          we_s      = win_b_s ? wbs_b_we_i  : wbs_a_we_i;
          addr_s    = win_b_s ? wbs_b_adr_i : wbs_a_adr_i;
          din_s     = win_b_s ? wbs_b_dat_i : wbs_a_dat_i;
          wmask_s   = win_b_s ? wbs_b_sel_i : wbs_a_sel_i;
          csb_s     = 1'b0;
          web_s     = win_b_s ? ~wbs_b_we_i : ~wbs_a_we_i;
          state_s   = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        csb_s = 1'b1;
        web_s = 1'b1;
        if (!owner_cyc_s) begin
          ptr_s   = ~grant_b_r;
          state_s = IDLE;
        end else if (we_r) begin
          ack_a_s = ~grant_b_r;
          ack_b_s = grant_b_r;
          state_s = ACK;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (!owner_cyc_s) begin
          ptr_s   = ~grant_b_r;
          state_s = IDLE;
        end else begin
          if (grant_b_r) begin
            dat_b_s = ram_dout0;
          end else begin
            dat_a_s = ram_dout0;
          end
          ack_a_s = ~grant_b_r;
          ack_b_s = grant_b_r;
          state_s = ACK;
        end
      end
      ACK: begin
        ptr_s   = ~grant_b_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset drops any access in flight without an ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= IDLE;
      ptr_r     <= 1'b0;
      grant_b_r <= 1'b0;
      we_r      <= 1'b0;
      csb_r     <= 1'b1;
      web_r     <= 1'b1;
      wmask_r   <= 4'd0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      din_r     <= 32'd0;
      ack_a_r   <= 1'b0;
      ack_b_r   <= 1'b0;
      dat_a_r   <= 32'd0;
      dat_b_r   <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      grant_b_r <= grant_b_s;
      we_r      <= we_s;
      csb_r     <= csb_s;
      web_r     <= web_s;
      wmask_r   <= wmask_s;
      addr_r    <= addr_s;
      din_r     <= din_s;
      ack_a_r   <= ack_a_s;
      ack_b_r   <= ack_b_s;
      dat_a_r   <= dat_a_s;
      dat_b_r   <= dat_b_s;
      busy_r    <= busy_s;
    end
  end

  assign ram_clk0    = wb_clk_i;
  assign ram_csb0    = csb_r;
  assign ram_web0    = web_r;
  assign ram_wmask0  = wmask_r;
  assign ram_addr0   = addr_r;
  assign ram_din0    = din_r;
  assign wbs_a_ack_o = ack_a_r;
  assign wbs_b_ack_o = ack_b_r;
  assign wbs_a_dat_o = dat_a_r;
  assign wbs_b_dat_o = dat_b_r;
  assign grant_b_o   = grant_b_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// Bench for wb_openram_arbiter: macro model, transaction-level reference model
// compared every cycle, directed scenarios plus randomized two-master traffic.
module tb_wb_openram_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_stb, a_cyc, a_we, a_ack;
  logic [3:0]    a_sel;
  logic [31:0]   a_dat, a_dout;
  logic [AW-1:0] a_adr;
  logic          b_stb, b_cyc, b_we, b_ack;
  logic [3:0]    b_sel;
  logic [31:0]   b_dat, b_dout;
  logic [AW-1:0] b_adr;
  logic          ram_clk0, ram_csb0, ram_web0;
  logic [3:0]    ram_wmask0;
  logic [AW-1:0] ram_addr0;
  logic [31:0]   ram_din0, ram_dout0;
  logic          grant_b, busy;

  logic [31:0]   mem [256];
  int            n_chk = 0;
  int            n_err = 0;
  int            cyc_n = 0;
  bit            dut_grants[$];

  // reference model: transaction age since grant (0 = no transaction)
  bit            mvalid = 1'b0;
  int            age = 0;
  int            last = 2;
  bit            own_b, own_we, rr_b, e_grant_b;
  logic [AW-1:0] own_adr;
  logic [31:0]   own_dat, rd_val, e_dat_a, e_dat_b;
  logic [3:0]    own_sel;
  logic [31:0]   ref_mem [256];

  wb_openram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_a_stb_i(a_stb), .wbs_a_cyc_i(a_cyc), .wbs_a_we_i(a_we), .wbs_a_sel_i(a_sel),
    .wbs_a_dat_i(a_dat), .wbs_a_adr_i(a_adr), .wbs_a_ack_o(a_ack), .wbs_a_dat_o(a_dout),
    .wbs_b_stb_i(b_stb), .wbs_b_cyc_i(b_cyc), .wbs_b_we_i(b_we), .wbs_b_sel_i(b_sel),
    .wbs_b_dat_i(b_dat), .wbs_b_adr_i(b_adr), .wbs_b_ack_o(b_ack), .wbs_b_dat_o(b_dout),
    .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0), .ram_wmask0(ram_wmask0),
    .ram_addr0(ram_addr0), .ram_din0(ram_din0), .ram_dout0(ram_dout0),
    .grant_b_o(grant_b), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // OpenRAM port 0 behaviour: sample on rising edge, read data valid next cycle.
  always @(posedge ram_clk0) begin
    if (ram_csb0 === 1'b0) begin
      if (ram_web0 === 1'b0) begin
        for (int k = 0; k < 4; k++)
          if (ram_wmask0[k]) mem[ram_addr0][8*k +: 8] <= ram_din0[8*k +: 8];
      end else begin
        ram_dout0 <= mem[ram_addr0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_step();
    bit ra, rb;
    if (mvalid) begin
      chk("csb", 32'(ram_csb0), 32'(age != 1));
      chk("busy", 32'(busy), 32'(age != 0));
      chk("grant_b", 32'(grant_b), 32'(e_grant_b));
      chk("ack_a", 32'(a_ack), 32'(age == last && !own_b));
      chk("ack_b", 32'(b_ack), 32'(age == last && own_b));
      chk("dat_a", a_dout, e_dat_a);
      chk("dat_b", b_dout, e_dat_b);
      if (age == 1) begin
        chk("addr", 32'(ram_addr0), 32'(own_adr));
        chk("din", ram_din0, own_dat);
        chk("wmask", 32'(ram_wmask0), 32'(own_sel));
        chk("web", 32'(ram_web0), 32'(!own_we));
      end
      if (ram_csb0 === 1'b0) dut_grants.push_back(grant_b);
    end
    ra = a_cyc && a_stb;
    rb = b_cyc && b_stb;
    if (rst) begin
      mvalid = 1'b1; age = 0; rr_b = 1'b0; e_grant_b = 1'b0;
      e_dat_a = 32'd0; e_dat_b = 32'd0;
    end else if (mvalid) begin
      if (age == 0) begin
        if (ra || rb) begin
          own_b   = (ra && rb) ? rr_b : rb;
          own_we  = own_b ? b_we  : a_we;
          own_adr = own_b ? b_adr : a_adr;
          own_dat = own_b ? b_dat : a_dat;
          own_sel = own_b ? b_sel : a_sel;
          e_grant_b = own_b;
          last = own_we ? 2 : 3;
          age  = 1;
          if (own_we) begin
            for (int k = 0; k < 4; k++)
              if (own_sel[k]) ref_mem[own_adr][8*k +: 8] = own_dat[8*k +: 8];
          end else begin
            rd_val = ref_mem[own_adr];
          end
        end
      end else if (age < last && !(own_b ? b_cyc : a_cyc)) begin
        age = 0; rr_b = !own_b;
      end else if (age == last) begin
        age = 0; rr_b = !own_b;
      end else begin
        age++;
        if (age == last && !own_we) begin
          if (own_b) e_dat_b = rd_val;
          else       e_dat_a = rd_val;
        end
      end
    end
  endtask

  task automatic drive(input bit pb, input bit on, input bit we, input logic [AW-1:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    if (pb) begin
      b_cyc = on; b_stb = on; b_we = we; b_adr = adr; b_dat = dat; b_sel = sel;
    end else begin
      a_cyc = on; a_stb = on; a_we = we; a_adr = adr; a_dat = dat; a_sel = sel;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the request is dropped.
  task automatic xfer(input bit pb, input bit we, input logic [AW-1:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output int lat);
    int start;
    bit got;
    drive(pb, 1'b1, we, adr, dat, sel);
    start = cyc_n; got = 1'b0; lat = -1; rd = 32'd0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (pb ? b_ack : a_ack) begin
        got = 1'b1; lat = cyc_n - start; rd = pb ? b_dout : a_dout;
      end
    end
    chk(pb ? "ack_seen_b" : "ack_seen_a", 32'(got), 32'd1);
    @(posedge clk); #1;
    drive(pb, 1'b0, we, adr, dat, sel);
  endtask

  task automatic rnd_xfer(input bit pb);
    logic [31:0] rd;
    int lat;
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    xfer(pb, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
         4'($urandom_range(0, 15)), rd, lat);
  endtask

  task automatic stimulus();
    logic [31:0] rd, rd_a, rd_b, r0, r1, r2, r3;
    int lat, lat_a, lat_b, l0, l1, l2, l3, csb_lo, ackb_n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_csb", 32'(ram_csb0), 32'd1);
    chk("rst_web", 32'(ram_web0), 32'd1);
    chk("rst_wmask", 32'(ram_wmask0), 32'd0);
    chk("rst_addr", 32'(ram_addr0), 32'd0);
    chk("rst_din", ram_din0, 32'd0);
    chk("rst_dat_a", a_dout, 32'd0);
    chk("rst_dat_b", b_dout, 32'd0);
    chk("rst_grant", 32'(grant_b), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) xfer(1'b0, 1'b1, AW'(i), 32'hC0DE_0000 + 32'(i), 4'hF, rd, lat);

    xfer(1'b0, 1'b1, 8'h05, 32'hDEAD_BEEF, 4'hF, rd, lat);
    chk("wr_latency", 32'(lat), 32'd2);
    xfer(1'b0, 1'b0, 8'h05, 32'd0, 4'hF, rd, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data", rd, 32'hDEAD_BEEF);

    xfer(1'b0, 1'b1, 8'h10, 32'h1122_3344, 4'hF, rd, lat);
    xfer(1'b0, 1'b1, 8'h10, 32'hAABB_CCDD, 4'b0101, rd, lat);
    xfer(1'b0, 1'b0, 8'h10, 32'd0, 4'hF, rd, lat);
    chk("mask_data", rd, 32'h11BB_33DD);
    xfer(1'b0, 1'b1, 8'h10, 32'hFFFF_FFFF, 4'b0000, rd, lat);
    chk("sel0_latency", 32'(lat), 32'd2);
    xfer(1'b0, 1'b0, 8'h10, 32'd0, 4'hF, rd, lat);
    chk("sel0_data", rd, 32'h11BB_33DD);

    // reset during ISSUE of a write; pointer was left at B
    drive(1'b0, 1'b1, 1'b1, 8'h20, 32'h1234_5678, 4'hF);
    @(posedge clk); #1;
    chk("issue_csb", 32'(ram_csb0), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'h20, 32'h1234_5678, 4'hF);
    chk("midrst_csb", 32'(ram_csb0), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ack", 32'(a_ack), 32'd0);

    dut_grants.delete();
    fork
      xfer(1'b0, 1'b0, 8'h01, 32'd0, 4'hF, rd_a, lat_a);
      xfer(1'b1, 1'b0, 8'h02, 32'd0, 4'hF, rd_b, lat_b);
    join
    chk("sim_lat_a", 32'(lat_a), 32'd3);
    chk("sim_lat_b", 32'(lat_b), 32'd7);
    chk("sim_dat_a", rd_a, 32'hC0DE_0001);
    chk("sim_dat_b", rd_b, 32'hC0DE_0002);
    chk("sim_ngrants", 32'(dut_grants.size()), 32'd2);
    if (dut_grants.size() >= 2) begin
      chk("sim_first", 32'(dut_grants[0]), 32'd0);
      chk("sim_second", 32'(dut_grants[1]), 32'd1);
    end

    // B read aborted in WAIT
    drive(1'b1, 1'b1, 1'b0, 8'h03, 32'd0, 4'hF);
    csb_lo = 0; ackb_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ram_csb0 === 1'b0) csb_lo++;
      if (b_ack !== 1'b0) ackb_n++;
      @(posedge clk); #1;
      if (i == 1) b_cyc = 1'b0;
    end
    b_stb = 1'b0;
    chk("abort_csb_cycles", 32'(csb_lo), 32'd1);
    chk("abort_acks", 32'(ackb_n), 32'd0);
    chk("abort_dat_b", b_dout, 32'hC0DE_0002);
    xfer(1'b0, 1'b0, 8'h04, 32'd0, 4'hF, rd, lat);
    chk("post_abort_lat", 32'(lat), 32'd3);
    chk("post_abort_dat", rd, 32'hC0DE_0004);
    xfer(1'b1, 1'b1, 8'h3F, 32'h0BAD_F00D, 4'hF, rd, lat);

    // continuous writes from both ports
    dut_grants.delete();
    fork
      begin
        xfer(1'b0, 1'b1, 8'h30, 32'hA000_0000, 4'hF, r0, l0);
        xfer(1'b0, 1'b1, 8'h31, 32'hA000_0001, 4'hF, r0, l0);
        xfer(1'b0, 1'b1, 8'h32, 32'hA000_0002, 4'hF, r1, l1);
        xfer(1'b0, 1'b1, 8'h33, 32'hA000_0003, 4'hF, r1, l1);
      end
      begin
        xfer(1'b1, 1'b1, 8'h38, 32'hB000_0000, 4'hF, r2, l2);
        xfer(1'b1, 1'b1, 8'h39, 32'hB000_0001, 4'hF, r2, l2);
        xfer(1'b1, 1'b1, 8'h3A, 32'hB000_0002, 4'hF, r3, l3);
        xfer(1'b1, 1'b1, 8'h3B, 32'hB000_0003, 4'hF, r3, l3);
      end
    join
    chk("rr_ngrants", 32'(dut_grants.size()), 32'd8);
    for (int k = 0; k < 8 && k < dut_grants.size(); k++)
      chk("rr_order", 32'(dut_grants[k]), 32'(k % 2));

    fork
      for (int i = 0; i < 40; i++) rnd_xfer(1'b0);
      for (int j = 0; j < 40; j++) rnd_xfer(1'b1);
    join
    repeat (4) @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, 32'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, '0, 32'd0, 4'd0);
    fork
      forever begin
        @(negedge clk);
        model_step();
      end
      stimulus();
    join_any
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
